// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave FIFO block.
package spi_pkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam int unsigned SPI_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACTIVE
    } spi_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word reads as zero while empty.
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_slave_fifo.sv
// SPI slave (all four modes) with RX/TX FIFOs, clocked entirely by spi_clk_i.
// Define SPI_SLAVE_FIFO_ERR_EN to add the rx_overflow_o / tx_underflow_o pulse outputs.
module spi_slave_fifo
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic              spi_clk_i,
    input  logic              rst_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    input  logic              sck_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o
`ifdef SPI_SLAVE_FIFO_ERR_EN
    ,
    output logic              rx_overflow_o,
    output logic              tx_underflow_o
`endif
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [SPI_SYNC_STAGES-1:0] sck_sync;
    logic [SPI_SYNC_STAGES-1:0] cs_sync;
    logic [SPI_SYNC_STAGES-1:0] mosi_sync;
    logic sck_s, cs_s, mosi_s, sck_d, cs_d;
    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic leading, trailing, in_word, sample_edge, shift_edge, word_done, tx_load;

    spi_state_e        state, state_next;
    spi_mode_t         mode;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift, rx_word;
    logic [DATA_W-1:0] tx_shift, tx_shifted, tx_word;
    logic              skip_shift;
    logic              rx_push;
    logic              rx_full, rx_empty;
    logic              tx_full, tx_empty;
    logic [DATA_W-1:0] tx_head;

    assign sck_s  = sck_sync[SPI_SYNC_STAGES-1];
    assign cs_s   = cs_sync[SPI_SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SPI_SYNC_STAGES-1];

    always_ff @(posedge spi_clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SPI_SYNC_STAGES-2:0], sck_i};
            cs_sync   <= {cs_sync[SPI_SYNC_STAGES-2:0], cs_n_i};
            mosi_sync <= {mosi_sync[SPI_SYNC_STAGES-2:0], mosi_i};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    assign sck_rise = sck_s && !sck_d;
    assign sck_fall = !sck_s && sck_d;
    assign cs_rise  = cs_s && !cs_d;
    assign cs_fall  = !cs_s && cs_d;

    assign leading     = mode.cpol ? sck_fall : sck_rise;
    assign trailing    = mode.cpol ? sck_rise : sck_fall;
    assign in_word     = (state == ACTIVE) && !cs_rise;
    assign sample_edge = in_word && (mode.cpha ? trailing : leading);
    assign shift_edge  = in_word && (mode.cpha ? leading : trailing);
    assign word_done   = sample_edge && (bit_cnt == LAST_BIT);
    assign tx_load     = (state == LOAD) || word_done;
    assign tx_word     = tx_empty ? '0 : tx_head;

    assign rx_word    = MSB_FIRST ? {rx_shift[DATA_W-2:0], mosi_s} : {mosi_s, rx_shift[DATA_W-1:1]};
    assign tx_shifted = MSB_FIRST ? {tx_shift[DATA_W-2:0], 1'b0} : {1'b0, tx_shift[DATA_W-1:1]};

    always_ff @(posedge spi_clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = LOAD;
            LOAD:    state_next = ACTIVE;
            ACTIVE:  state_next = ACTIVE;
            default: state_next = IDLE;
        endcase
        if (cs_rise) state_next = IDLE;
    end

    always_comb begin
        miso_oe_o = 1'b0;
        miso_o    = 1'b0;
        case (state)
            LOAD: begin
                miso_oe_o = 1'b1;
                miso_o    = MSB_FIRST ? tx_word[DATA_W-1] : tx_word[0];
            end
            ACTIVE: begin
                miso_oe_o = 1'b1;
                miso_o    = MSB_FIRST ? tx_shift[DATA_W-1] : tx_shift[0];
            end
            default: ;
        endcase
    end

    // A freshly loaded word is already on miso, so the next shift edge only
    // consumes the skip flag; at frame start that applies to cpha=1 alone.
    always_ff @(posedge spi_clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode       <= '0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            skip_shift <= 1'b0;
            rx_push    <= 1'b0;
        end else begin
            rx_push <= word_done;
            if (state == IDLE) begin
                bit_cnt    <= '0;
                skip_shift <= 1'b0;
                if (cs_fall) mode <= {cpol_i, cpha_i};
            end
            if (tx_load) begin
                tx_shift   <= tx_word;
                skip_shift <= (state == ACTIVE) || mode.cpha;
            end else if (shift_edge) begin
                if (skip_shift) skip_shift <= 1'b0;
                else            tx_shift   <= tx_shifted;
            end
            if (sample_edge) begin
                rx_shift <= rx_word;
                bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SPI_SLAVE_FIFO_ERR_EN
    logic zero_pending;

    // A zero-filled word reloaded mid-frame only counts once its first bit is
    // actually exchanged; a cs_n rise before that discards it silently.
    always_ff @(posedge spi_clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_overflow_o  <= 1'b0;
            tx_underflow_o <= 1'b0;
            zero_pending   <= 1'b0;
        end else begin
            rx_overflow_o  <= rx_push && rx_full && !rx_ready_i;
            tx_underflow_o <= ((state == LOAD) && tx_empty) || (zero_pending && sample_edge);
            if (!in_word)         zero_pending <= 1'b0;
            else if (word_done)   zero_pending <= tx_empty;
            else if (sample_edge) zero_pending <= 1'b0;
        end
    end
`endif

    spi_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (spi_clk_i),
        .rst       (rst_i),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_ready_i),
        .pop_data  (rx_data_o),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    spi_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (spi_clk_i),
        .rst       (rst_i),
        .push      (tx_valid_i && !tx_full),
        .push_data (tx_data_i),
        .pop       (tx_load),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    assign tx_ready_o = !tx_full;
    assign rx_valid_o = !rx_empty;

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Scoreboard bench: an 8-bit MSB-first slave and a 16-bit LSB-first slave share sck/mosi.
module tb_spi_slave_fifo;

    localparam int unsigned H = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpol = 1'b0, cpha = 1'b0, sck = 1'b0, mosi = 1'b0;
    logic        cs_n_a = 1'b1, cs_n_b = 1'b1;
    logic [7:0]  tx_data_a = '0;
    logic [15:0] tx_data_b = '0;
    logic        tx_valid_a = 1'b0, tx_valid_b = 1'b0;
    logic        tx_ready_a, tx_ready_b;
    logic [7:0]  rx_data_a;
    logic [15:0] rx_data_b;
    logic        rx_valid_a, rx_valid_b;
    logic        rx_ready_a = 1'b1, rx_ready_b = 1'b1;
    logic        miso_a, miso_b, oe_a, oe_b;
`ifdef SPI_SLAVE_FIFO_ERR_EN
    logic        ovf_a, unf_a, ovf_b, unf_b;
    int          ovf_cnt = 0, unf_cnt = 0;
`endif

    int          n_vec = 0, n_bad = 0;
    int          cyc = 0, lat_start = 0, last_lat = 0;
    logic [31:0] exp_rx_a[$];
    logic [31:0] exp_rx_b[$];
    logic [31:0] exp_miso[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_slave_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) u_dut_a (
        .spi_clk_i(clk), .rst_i(rst), .cpol_i(cpol), .cpha_i(cpha),
        .tx_data_i(tx_data_a), .tx_valid_i(tx_valid_a), .tx_ready_o(tx_ready_a),
        .rx_data_o(rx_data_a), .rx_valid_o(rx_valid_a), .rx_ready_i(rx_ready_a),
        .sck_i(sck), .cs_n_i(cs_n_a), .mosi_i(mosi), .miso_o(miso_a), .miso_oe_o(oe_a)
`ifdef SPI_SLAVE_FIFO_ERR_EN
        , .rx_overflow_o(ovf_a), .tx_underflow_o(unf_a)
`endif
    );

    spi_slave_fifo #(.DATA_W(16), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) u_dut_b (
        .spi_clk_i(clk), .rst_i(rst), .cpol_i(cpol), .cpha_i(cpha),
        .tx_data_i(tx_data_b), .tx_valid_i(tx_valid_b), .tx_ready_o(tx_ready_b),
        .rx_data_o(rx_data_b), .rx_valid_o(rx_valid_b), .rx_ready_i(rx_ready_b),
        .sck_i(sck), .cs_n_i(cs_n_b), .mosi_i(mosi), .miso_o(miso_b), .miso_oe_o(oe_b)
`ifdef SPI_SLAVE_FIFO_ERR_EN
        , .rx_overflow_o(ovf_b), .tx_underflow_o(unf_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (rx_valid_a && rx_ready_a) begin
            last_lat = cyc - lat_start;
            if (exp_rx_a.size() == 0) chk("rx_a_spurious_qlen", 32'(exp_rx_a.size()), 32'd1);
            else                      chk("rx_a_data", 32'(rx_data_a), exp_rx_a.pop_front());
        end
        if (rx_valid_b && rx_ready_b) begin
            if (exp_rx_b.size() == 0) chk("rx_b_spurious_qlen", 32'(exp_rx_b.size()), 32'd1);
            else                      chk("rx_b_data", 32'(rx_data_b), exp_rx_b.pop_front());
        end
`ifdef SPI_SLAVE_FIFO_ERR_EN
        if (ovf_a) ovf_cnt++;
        if (unf_a) unf_cnt++;
`endif
    end

    task automatic push_tx(input bit sel_b, input logic [31:0] data, input bit expect_out);
        int unsigned n;
        if (expect_out) exp_miso.push_back(data);
        if (sel_b) begin tx_data_b = data[15:0]; tx_valid_b = 1'b1; end
        else       begin tx_data_a = data[7:0];  tx_valid_a = 1'b1; end
        n = 0;
        while (!(sel_b ? tx_ready_b : tx_ready_a) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) chk("tx_ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        cpol = pol;
        cpha = pha;
        sck  = pol;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_begin(input bit sel_b);
        if (sel_b) cs_n_b = 1'b0; else cs_n_a = 1'b0;
        repeat (H) @(negedge clk);
        chk("oe_in_frame", 32'(sel_b ? oe_b : oe_a), 32'd1);
    endtask

    task automatic frame_end(input bit sel_b);
        repeat (H) @(negedge clk);
        cs_n_a = 1'b1;
        cs_n_b = 1'b1;
        repeat (2*H) @(negedge clk);
        chk("oe_after_frame", 32'(sel_b ? oe_b : oe_a), 32'd0);
        chk("miso_after_frame", 32'(sel_b ? miso_b : miso_a), 32'd0);
    endtask

    task automatic xfer_word(input bit sel_b, input int unsigned width, input bit lsb,
                             input logic [31:0] out_word, input int unsigned nbits,
                             output logic [31:0] in_word);
        in_word = '0;
        for (int unsigned i = 0; i < nbits; i++) begin
            int unsigned idx;
            idx = lsb ? i : width - 1 - i;
            if (!cpha) begin
                mosi = out_word[idx];
                repeat (H) @(negedge clk);
                sck = ~cpol;
                in_word[idx] = sel_b ? miso_b : miso_a;
                if (i == width - 1) lat_start = cyc;
                repeat (H) @(negedge clk);
                sck = cpol;
            end else begin
                repeat (H) @(negedge clk);
                sck  = ~cpol;
                mosi = out_word[idx];
                repeat (H) @(negedge clk);
                sck = cpol;
                in_word[idx] = sel_b ? miso_b : miso_a;
                if (i == width - 1) lat_start = cyc;
            end
        end
    endtask

    task automatic send_word(input bit sel_b, input logic [31:0] data, input bit keep, input string tag);
        logic [31:0] got;
        int unsigned w;
        w = sel_b ? 16 : 8;
        if (keep) begin
            if (sel_b) exp_rx_b.push_back(data);
            else       exp_rx_a.push_back(data);
        end
        xfer_word(sel_b, w, sel_b, data, w, got);
        if (exp_miso.size() == 0) chk({tag, "_miso_qlen"}, 32'(exp_miso.size()), 32'd1);
        else                      chk({tag, "_miso"}, got, exp_miso.pop_front());
    endtask

    initial begin
        logic [31:0] junk;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready_a", 32'(tx_ready_a), 32'd1);
        chk("rst_rx_valid_a", 32'(rx_valid_a), 32'd0);
        chk("rst_rx_data_a", 32'(rx_data_a), 32'd0);
        chk("rst_miso_a", 32'(miso_a), 32'd0);
        chk("rst_oe_a", 32'(oe_a), 32'd0);
        chk("rst_tx_ready_b", 32'(tx_ready_b), 32'd1);
        chk("rst_rx_valid_b", 32'(rx_valid_b), 32'd0);
`ifdef SPI_SLAVE_FIFO_ERR_EN
        chk("rst_err_pulses", {30'd0, ovf_a, unf_a}, 32'd0);
`endif
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // mode 0 basic exchange and RX latency
        set_mode(1'b0, 1'b0);
        push_tx(1'b0, 32'hA5, 1'b1);
`ifdef SPI_SLAVE_FIFO_ERR_EN
        unf_cnt = 0;
`endif
        frame_begin(1'b0);
        send_word(1'b0, 32'h3C, 1'b1, "mode0");
        frame_end(1'b0);
        chk("rx_latency_in_4_to_6", 32'(last_lat >= 4 && last_lat <= 6), 32'd1);
`ifdef SPI_SLAVE_FIFO_ERR_EN
        chk("mode0_no_underflow", 32'(unf_cnt), 32'd0);
`endif

        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0]);
            push_tx(1'b0, 32'h81, 1'b1);
            frame_begin(1'b0);
            send_word(1'b0, 32'h7E, 1'b1, $sformatf("mode%0d", m));
            frame_end(1'b0);
        end

        // 16-bit LSB-first slave
        set_mode(1'b0, 1'b0);
        push_tx(1'b1, 32'hBEEF, 1'b1);
        frame_begin(1'b1);
        send_word(1'b1, 32'h1234, 1'b1, "lsb16");
        frame_end(1'b1);

        // RX overflow: four words kept, fifth dropped; fifth TX word zero-filled
        rx_ready_a = 1'b0;
        for (int i = 0; i < 4; i++) push_tx(1'b0, 32'hE1 + 32'(i), 1'b1);
        exp_miso.push_back(32'h00);
`ifdef SPI_SLAVE_FIFO_ERR_EN
        ovf_cnt = 0;
        unf_cnt = 0;
`endif
        frame_begin(1'b0);
        for (int i = 0; i < 5; i++) send_word(1'b0, 32'h11 * 32'(i + 1), i < 4, "ovf");
        frame_end(1'b0);
        chk("ovf_rx_full_valid", 32'(rx_valid_a), 32'd1);
        rx_ready_a = 1'b1;
        repeat (10) @(negedge clk);
        chk("ovf_fifth_dropped", 32'(rx_valid_a), 32'd0);
`ifdef SPI_SLAVE_FIFO_ERR_EN
        chk("ovf_pulse_count", 32'(ovf_cnt), 32'd1);
        chk("ovf_underflow_count", 32'(unf_cnt), 32'd1);
`endif

        // TX empty at cs_n fall
`ifdef SPI_SLAVE_FIFO_ERR_EN
        unf_cnt = 0;
`endif
        exp_miso.push_back(32'h00);
        frame_begin(1'b0);
        send_word(1'b0, 32'h96, 1'b1, "underflow");
        frame_end(1'b0);
`ifdef SPI_SLAVE_FIFO_ERR_EN
        chk("underflow_pulse_count", 32'(unf_cnt), 32'd1);
`endif

        // aborted partial word, then a clean word
        push_tx(1'b0, 32'h0F, 1'b0);
        frame_begin(1'b0);
        xfer_word(1'b0, 8, 1'b0, 32'hFF, 3, junk);
        frame_end(1'b0);
        push_tx(1'b0, 32'hC3, 1'b1);
        frame_begin(1'b0);
        send_word(1'b0, 32'h55, 1'b1, "after_abort");
        frame_end(1'b0);

        for (int i = 0; i < 200 && (exp_rx_a.size() != 0 || exp_rx_b.size() != 0); i++)
            @(negedge clk);
        chk("rx_a_left", 32'(exp_rx_a.size()), 32'd0);
        chk("rx_b_left", 32'(exp_rx_b.size()), 32'd0);
        chk("miso_left", 32'(exp_miso.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
        $fatal(1);
    end

endmodule
